// File: rtl/fpgaaudiosoc_usb_irq_pio.sv
`default_nettype none
// fpgaaudiosoc_usb_irq_pio: Avalon-MM input PIO with synchronizer, edge capture and level irq.
// Revision 1.0
module fpgaaudiosoc_usb_irq_pio #(
   parameter int unsigned      WIDTH       = 1,
   parameter int unsigned      EDGE_TYPE   = 0,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] MASK_RESET  = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
   localparam int unsigned CW        = $clog2(PRIME_MAX + 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [CW-1:0]    prime_q;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [31:0]      readdata_q, readdata_d;

   logic [WIDTH-1:0] s_w;
   logic [WIDTH-1:0] det_w;
   logic             primed_w;
   logic             wr_w;
   logic             rd_w;
   logic             unused_ok;

   assign s_w       = sync_q[SYNC_STAGES-1];
   assign primed_w  = (prime_q == PRIME_MAX[CW-1:0]);
   assign wr_w      = chipselect & ~write_n;
   assign rd_w      = chipselect & ~read_n;
   assign unused_ok = &{1'b0, writedata};

   // Detection stays off until the synchronizer and prev hold real samples.
   always_comb begin
      det_w = '0;
      if (primed_w) begin
         case (EDGE_TYPE)
            0:       det_w = s_w & ~prev_q;
            1:       det_w = ~s_w & prev_q;
            default: det_w = (s_w & ~prev_q) | (~s_w & prev_q);
         endcase
      end
   end

   // Clear first, then OR in new edges so a coincident set wins.
   always_comb begin
      edgecap_d = edgecap_q;
      mask_d    = mask_q;
      if (wr_w && address == 2'd3) edgecap_d = edgecap_d & ~writedata[WIDTH-1:0];
      if (wr_w && address == 2'd2) mask_d = writedata[WIDTH-1:0];
      edgecap_d = edgecap_d | det_w;
   end

   // Read mux uses pre-write register values.
   always_comb begin
      readdata_d = readdata_q;
      if (rd_w) begin
         readdata_d = '0;
         case (address)
            2'd0:    readdata_d[WIDTH-1:0] = s_w;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
         prev_q     <= '0;
         prime_q    <= '0;
         edgecap_q  <= '0;
         mask_q     <= MASK_RESET;
         readdata_q <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
         prev_q <= s_w;
         if (!primed_w) prime_q <= prime_q + CW'(1);
         edgecap_q  <= edgecap_d;
         mask_q     <= mask_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_fpgaaudiosoc_usb_irq_pio.sv
`default_nettype none
// tb_fpgaaudiosoc_usb_irq_pio: self-checking bench for two PIO configurations.
// Revision 1.0
module tb_fpgaaudiosoc_usb_irq_pio;

   localparam logic [3:0] MASK4 = 4'hA;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        read_n, write_n;
   logic [31:0] writedata;
   logic        cs1, cs4;
   logic [0:0]  in1;
   logic [3:0]  in4;
   logic [31:0] rd1, rd4;
   logic        irq1, irq4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
      bit          sel4;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      int          op;       // 0 wait, 1 write, 2 read
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  inp;
      int          waitc;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;
   vec_t vt[16];

   fpgaaudiosoc_usb_irq_pio #(.WIDTH(1), .EDGE_TYPE(0), .SYNC_STAGES(2), .MASK_RESET(1'b0)) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .in_port(in1), .readdata(rd1), .irq(irq1)
   );

   fpgaaudiosoc_usb_irq_pio #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2), .MASK_RESET(MASK4)) dut4 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs4),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .in_port(in4), .readdata(rd4), .irq(irq4)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pop_check();
      sb_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb_q.pop_front();
         check(e.name, e.sel4 ? rd4 : rd1, e.exp);
      end
   endtask

   task automatic wr(input bit sel4, input logic [1:0] a, input logic [31:0] d);
      cs1 = !sel4; cs4 = sel4; address = a; writedata = d; write_n = 1'b0;
      tick();
      cs1 = 1'b0; cs4 = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input bit sel4, input logic [1:0] a, input logic [31:0] exp, input string name);
      sb_t e;
      cs1 = !sel4; cs4 = sel4; address = a; read_n = 1'b0;
      e.name = name; e.exp = exp; e.sel4 = sel4;
      sb_q.push_back(e);
      tick();
      cs1 = 1'b0; cs4 = 1'b0; read_n = 1'b1;
      pop_check();
   endtask

   initial begin
      sb_t e;
      vt[0]  = '{0, 2'd0, 32'h0,        4'h6, 5, 32'h0, 1'b1};
      vt[1]  = '{2, 2'd3, 32'h0,        4'h6, 0, 32'h9, 1'b1};
      vt[2]  = '{2, 2'd1, 32'h0,        4'h6, 0, 32'h0, 1'b1};
      vt[3]  = '{2, 2'd0, 32'h0,        4'h6, 0, 32'h6, 1'b1};
      vt[4]  = '{1, 2'd3, 32'h1,        4'h6, 0, 32'h0, 1'b1};
      vt[5]  = '{2, 2'd3, 32'h0,        4'h6, 0, 32'h8, 1'b1};
      vt[6]  = '{1, 2'd2, 32'h5,        4'h6, 0, 32'h0, 1'b0};
      vt[7]  = '{2, 2'd2, 32'h0,        4'h6, 0, 32'h5, 1'b0};
      vt[8]  = '{1, 2'd0, 32'hF,        4'h6, 0, 32'h0, 1'b0};
      vt[9]  = '{2, 2'd0, 32'h0,        4'h6, 0, 32'h6, 1'b0};
      vt[10] = '{0, 2'd0, 32'h0,        4'h7, 5, 32'h0, 1'b1};
      vt[11] = '{2, 2'd3, 32'h0,        4'h7, 0, 32'h9, 1'b1};
      vt[12] = '{1, 2'd3, 32'hFFFFFFFF, 4'h7, 0, 32'h0, 1'b0};
      vt[13] = '{2, 2'd3, 32'h0,        4'h7, 0, 32'h0, 1'b0};
      vt[14] = '{1, 2'd2, 32'hFFFFFFF0, 4'h7, 0, 32'h0, 1'b0};
      vt[15] = '{2, 2'd2, 32'h0,        4'h7, 0, 32'h0, 1'b0};

      // Reset with inputs already high: no capture once primed.
      reset_n = 1'b0; address = 2'd0; read_n = 1'b1; write_n = 1'b1;
      writedata = '0; cs1 = 1'b0; cs4 = 1'b0; in1 = 1'b1; in4 = 4'hF;
      repeat (3) tick();
      check("rst_rd1", rd1, 32'h0);
      check("rst_rd4", rd4, 32'h0);
      check("rst_irq1", {31'b0, irq1}, 32'h0);
      check("rst_irq4", {31'b0, irq4}, 32'h0);
      reset_n = 1'b1;
      repeat (10) tick();
      rd(0, 2'd3, 32'h0, "prime_cap1");
      rd(0, 2'd0, 32'h1, "prime_data1");
      check("prime_irq1", {31'b0, irq1}, 32'h0);
      rd(1, 2'd3, 32'h0, "prime_cap4");
      rd(1, 2'd0, 32'hF, "prime_data4");
      rd(1, 2'd2, {28'h0, MASK4}, "mask_reset4");
      check("prime_irq4", {31'b0, irq4}, 32'h0);

      // Rising-only config ignores the falling edge, then latches a rise at 3 cycles.
      in1 = 1'b0;
      repeat (6) tick();
      rd(0, 2'd3, 32'h0, "fall_ignored");
      wr(0, 2'd2, 32'h1);
      check("mask_no_irq", {31'b0, irq1}, 32'h0);
      in1 = 1'b1;
      tick(); tick();
      check("edge_not_early", {31'b0, irq1}, 32'h0);
      tick();
      check("edge_latency", {31'b0, irq1}, 32'h1);
      rd(0, 2'd3, 32'h1, "cap_set1");
      wr(0, 2'd3, 32'h1);
      check("w1c_irq_drop", {31'b0, irq1}, 32'h0);

      // Capture while masked, then unmask.
      wr(0, 2'd2, 32'h0);
      in1 = 1'b0; repeat (5) tick();
      in1 = 1'b1; repeat (5) tick();
      rd(0, 2'd3, 32'h1, "cap_masked");
      check("masked_irq", {31'b0, irq1}, 32'h0);
      wr(0, 2'd2, 32'h1);
      check("unmask_irq", {31'b0, irq1}, 32'h1);

      // W1C lands on the same edge as a new capture: set wins.
      in1 = 1'b0; repeat (5) tick();
      in1 = 1'b1; tick(); tick();
      wr(0, 2'd3, 32'h1);
      check("setwins_irq", {31'b0, irq1}, 32'h1);
      rd(0, 2'd3, 32'h1, "setwins_cap");
      wr(0, 2'd3, 32'h1);
      check("clear_after", {31'b0, irq1}, 32'h0);

      // Any-edge, 4-bit configuration driven from the vector table.
      for (int i = 0; i < 16; i++) begin
         in4 = vt[i].inp;
         case (vt[i].op)
            0:       repeat (vt[i].waitc) tick();
            1:       wr(1, vt[i].addr, vt[i].wdata);
            default: rd(1, vt[i].addr, vt[i].exp_rd, $sformatf("vec%0d_rd", i));
         endcase
         check($sformatf("vec%0d_irq", i), {31'b0, irq4}, {31'b0, vt[i].exp_irq});
      end

      // Simultaneous read and write of IRQMASK returns the old value.
      cs4 = 1'b1; address = 2'd2; read_n = 1'b0; write_n = 1'b0; writedata = 32'h3;
      e.name = "rw_same_cycle"; e.exp = 32'h0; e.sel4 = 1'b1;
      sb_q.push_back(e);
      tick();
      cs4 = 1'b0; read_n = 1'b1; write_n = 1'b1;
      pop_check();
      rd(1, 2'd2, 32'h3, "rw_after");

      // Asynchronous reset while irq is high.
      in4 = 4'h5; repeat (5) tick();
      check("pre_rst_irq", {31'b0, irq4}, 32'h1);
      rd(1, 2'd2, 32'h3, "pre_rst_rd");
      #2 reset_n = 1'b0;
      #1;
      check("async_irq", {31'b0, irq4}, 32'h0);
      check("async_rd", rd4, 32'h0);
      tick(); tick();
      reset_n = 1'b1;
      repeat (10) tick();
      rd(1, 2'd2, {28'h0, MASK4}, "post_rst_mask4");
      rd(1, 2'd3, 32'h0, "post_rst_cap4");
      check("post_rst_irq4", {31'b0, irq4}, 32'h0);
      rd(0, 2'd2, 32'h0, "post_rst_mask1");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
